// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for a multi-cycle RV32I datapath. The datapath shares one memory
// and one ALU, and holds PC, OldPC, IR, MDR, A/B and ALUOut registers. Every
// instruction is stepped through FETCH/DECODE/EXECUTE/MEM/WB states. Each
// memory-access state stretches by MEM_WAIT wait cycles. A stall input freezes
// the sequence, and opcodes outside the supported set raise a one-cycle
// illegal pulse.
//
// Ports
//   clk, rst          rising-edge clock; synchronous active-high reset
//   opcode/func3/func7 instruction fields IR[6:0], IR[14:12], IR[31:25]
//   zero, negative    ALU flags used to resolve branches
//   stall             hold state/counter and block every write enable
//   PCWrite, IRWrite, MemWrite, RegWrite    write enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB     datapath mux selects
//   ALUControl, ImmSrc                      ALU operation / immediate format
//   illegal           one-cycle pulse in DECODE for an unsupported opcode
//   state             current state encoding (debug)

module multicycle_controller #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       negative,
  input  logic       stall,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_CALC = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic             last_wait;

  // Raw enables before stall/reset gating.
  logic pcw_raw;
  logic irw_raw;
  logic mw_raw;
  logic rw_raw;
  logic ill_raw;
  logic taken;

  // Only func7[5] matters for decode; the remaining bits are ignored.
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic use_sub);
    logic [2:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = use_sub ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  assign last_wait = (cnt == WAIT_LAST);

  // The counter restarts whenever the state changes. Only the wait states
  // ever loop on themselves, so this covers every entry into FETCH, MEMREAD
  // and MEMWRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_FETCH;
      cnt       <= '0;
    end else if (!stall) begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state) begin
        cnt <= '0;
      end else if (!last_wait) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = negative;
      3'b101:  taken = !negative;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_LUI:    ImmSrc = 3'b011;
      OP_JAL:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    nxt_state  = cur_state;
    pcw_raw    = 1'b0;
    irw_raw    = 1'b0;
    mw_raw     = 1'b0;
    rw_raw     = 1'b0;
    ill_raw    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;

    case (cur_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (last_wait) begin
          irw_raw   = 1'b1;
          pcw_raw   = 1'b1;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: nxt_state = S_MEMADR;
          OP_R:              nxt_state = S_EXEC_R;
          OP_I:              nxt_state = S_EXEC_I;
          OP_BRANCH:         nxt_state = S_BRANCH;
          OP_JAL:            nxt_state = S_JAL;
          OP_JALR:           nxt_state = S_JALR_CALC;
          OP_LUI:            nxt_state = S_LUI;
          default: begin
            ill_raw   = 1'b1;
            nxt_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        nxt_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (last_wait) nxt_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw_raw    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        if (last_wait) begin
          mw_raw    = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(func3, func7[5]);
        nxt_state  = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(func3, 1'b0);
        nxt_state  = S_ALUWB;
      end
      S_ALUWB: begin
        rw_raw    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        pcw_raw    = taken;
        nxt_state  = S_FETCH;
      end
      S_JAL, S_JALR_LINK: begin
        // PC takes the target already in ALUOut; the ALU forms OldPC + 4
        // so ALUWB can write the link value next cycle.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcw_raw   = 1'b1;
        nxt_state = S_ALUWB;
      end
      S_JALR_CALC: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        nxt_state = S_JALR_LINK;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        rw_raw    = 1'b1;
        nxt_state = S_FETCH;
      end
      default: nxt_state = S_FETCH;
    endcase
  end

  // Mux selects pass through untouched; only side effects are gated.
  assign PCWrite  = pcw_raw & ~stall & ~rst;
  assign IRWrite  = irw_raw & ~stall & ~rst;
  assign MemWrite = mw_raw  & ~stall & ~rst;
  assign RegWrite = rw_raw  & ~stall & ~rst;
  assign illegal  = ill_raw & ~stall & ~rst;
  assign state    = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       zero = 1'b0;
  logic       negative = 1'b0;
  logic       stall = 1'b0;

  // Index 0: MEM_WAIT = 0 instance; index 1: MEM_WAIT = 2 instance.
  logic [1:0]      pcw, adr, mw, irw, rw, ill;
  logic [1:0][1:0] res, srca, srcb;
  logic [1:0][2:0] alu, imm;
  logic [1:0][3:0] st;

  multicycle_controller #(.MEM_WAIT(0), .CNT_W(4)) u_w0 (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .negative(negative), .stall(stall),
    .PCWrite(pcw[0]), .AdrSrc(adr[0]), .MemWrite(mw[0]), .IRWrite(irw[0]),
    .RegWrite(rw[0]), .ResultSrc(res[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]),
    .ALUControl(alu[0]), .ImmSrc(imm[0]), .illegal(ill[0]), .state(st[0])
  );

  multicycle_controller #(.MEM_WAIT(2), .CNT_W(4)) u_w2 (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .negative(negative), .stall(stall),
    .PCWrite(pcw[1]), .AdrSrc(adr[1]), .MemWrite(mw[1]), .IRWrite(irw[1]),
    .RegWrite(rw[1]), .ResultSrc(res[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]),
    .ALUControl(alu[1]), .ImmSrc(imm[1]), .illegal(ill[1]), .state(st[1])
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, ill;
    logic       adr;
    logic [1:0] res, srca, srcb;
    logic [2:0] alu, imm;
  } ctl_t;

  typedef struct {
    bit    d;
    ctl_t  c;
    string nm;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Enable patterns {PCWrite, IRWrite, RegWrite, MemWrite, illegal}
  localparam logic [4:0] EN_NONE  = 5'b00000;
  localparam logic [4:0] EN_FETCH = 5'b11000;
  localparam logic [4:0] EN_PC    = 5'b10000;
  localparam logic [4:0] EN_RW    = 5'b00100;
  localparam logic [4:0] EN_MW    = 5'b00010;
  localparam logic [4:0] EN_ILL   = 5'b00001;

  function automatic ctl_t actual(input bit d);
    ctl_t a;
    a.st = st[d]; a.pcw = pcw[d]; a.irw = irw[d]; a.rw = rw[d]; a.mw = mw[d];
    a.ill = ill[d]; a.adr = adr[d]; a.res = res[d]; a.srca = srca[d];
    a.srcb = srcb[d]; a.alu = alu[d]; a.imm = imm[d];
    return a;
  endfunction

  // Monitor: one expected entry per cycle, checked mid-cycle.
  exp_t mon_e;
  ctl_t mon_a;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = actual(mon_e.d);
      vectors++;
      if (mon_a !== mon_e.c) begin
        miscompares++;
        $display("FAIL %s (mem_wait=%0d): got st=%0d en=%b sel=%b alu=%b imm=%b, expected st=%0d en=%b sel=%b alu=%b imm=%b",
                 mon_e.nm, mon_e.d ? 2 : 0,
                 mon_a.st, {mon_a.pcw, mon_a.irw, mon_a.rw, mon_a.mw, mon_a.ill},
                 {mon_a.adr, mon_a.res, mon_a.srca, mon_a.srcb}, mon_a.alu, mon_a.imm,
                 mon_e.c.st, {mon_e.c.pcw, mon_e.c.irw, mon_e.c.rw, mon_e.c.mw, mon_e.c.ill},
                 {mon_e.c.adr, mon_e.c.res, mon_e.c.srca, mon_e.c.srcb}, mon_e.c.alu, mon_e.c.imm);
      end
    end
  end

  // Push the expected outputs for the current cycle (inputs already set),
  // then advance to just after the next rising edge.
  task automatic step(input bit d, input int s, input logic [2:0] a,
                      input logic [2:0] im, input logic [4:0] en, input string nm);
    exp_t e;
    logic [6:0] sel;
    case (s)
      0:       sel = 7'b0_10_00_10;
      1:       sel = 7'b0_00_01_01;
      2:       sel = 7'b0_00_10_01;
      3:       sel = 7'b1_00_00_00;
      4:       sel = 7'b0_01_00_00;
      5:       sel = 7'b1_00_00_00;
      6:       sel = 7'b0_00_10_00;
      7:       sel = 7'b0_00_10_01;
      9:       sel = 7'b0_00_10_00;
      10, 12:  sel = 7'b0_00_01_10;
      11:      sel = 7'b0_00_10_01;
      13:      sel = 7'b0_11_00_00;
      default: sel = 7'b0_00_00_00;
    endcase
    e.d = d;
    e.nm = nm;
    e.c.st = 4'(s);
    {e.c.pcw, e.c.irw, e.c.rw, e.c.mw, e.c.ill} = en;
    {e.c.adr, e.c.res, e.c.srca, e.c.srcb} = sel;
    e.c.alu = a;
    e.c.imm = im;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; func3 = f3; func7 = f7;
  endtask

  task automatic reset_dut(input bit d);
    opcode = '0; stall = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    step(d, 0, 3'b000, 3'b000, EN_NONE, "reset");
    rst = 1'b0;
  endtask

  // MEM_WAIT = 0: FETCH, DECODE, EXEC_x, ALUWB
  task automatic alu_instr(input int exst, input logic [2:0] a, input string nm);
    step(0, 0, 3'b000, 3'b000, EN_FETCH, {nm, "_fetch"});
    step(0, 1, 3'b000, 3'b000, EN_NONE,  {nm, "_decode"});
    step(0, exst, a,   3'b000, EN_NONE,  {nm, "_exec"});
    step(0, 8, 3'b000, 3'b000, EN_RW,    {nm, "_wb"});
  endtask

  task automatic branch(input logic [2:0] f3, input logic z, input logic n,
                        input logic tk, input string nm);
    instr(7'b1100011, f3, 7'b0000000);
    zero = z; negative = n;
    step(0, 0, 3'b000, 3'b010, EN_FETCH, {nm, "_fetch"});
    step(0, 1, 3'b000, 3'b010, EN_NONE,  {nm, "_decode"});
    step(0, 9, 3'b001, 3'b010, tk ? EN_PC : EN_NONE, {nm, "_branch"});
    zero = 1'b0; negative = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_dut(0);

    // ALU decode on the MEM_WAIT = 0 instance
    instr(7'b0110011, 3'b000, 7'b0000000); alu_instr(6, 3'b000, "r_add");
    instr(7'b0110011, 3'b000, 7'b0100000); alu_instr(6, 3'b001, "r_sub");
    instr(7'b0110011, 3'b010, 7'b0000000); alu_instr(6, 3'b101, "r_slt");
    instr(7'b0110011, 3'b111, 7'b0000000); alu_instr(6, 3'b010, "r_and");
    instr(7'b0110011, 3'b001, 7'b0000000); alu_instr(6, 3'b000, "r_f3_001");
    instr(7'b0010011, 3'b100, 7'b0000000); alu_instr(7, 3'b100, "i_xor");
    instr(7'b0010011, 3'b110, 7'b0000000); alu_instr(7, 3'b011, "i_or");
    instr(7'b0010011, 3'b000, 7'b0100000); alu_instr(7, 3'b000, "i_add_f7");

    // Branches
    branch(3'b001, 1'b1, 1'b0, 1'b0, "bne_z1");
    branch(3'b001, 1'b0, 1'b0, 1'b1, "bne_z0");
    branch(3'b100, 1'b0, 1'b1, 1'b1, "blt_n1");
    branch(3'b000, 1'b1, 1'b0, 1'b1, "beq_z1");
    branch(3'b101, 1'b0, 1'b1, 1'b0, "bge_n1");
    branch(3'b010, 1'b1, 1'b1, 1'b0, "b_f3_010");

    // jalr
    instr(7'b1100111, 3'b000, 7'b0000000);
    step(0, 0,  3'b000, 3'b000, EN_FETCH, "jalr_fetch");
    step(0, 1,  3'b000, 3'b000, EN_NONE,  "jalr_decode");
    step(0, 11, 3'b000, 3'b000, EN_NONE,  "jalr_calc");
    step(0, 12, 3'b000, 3'b000, EN_PC,    "jalr_link");
    step(0, 8,  3'b000, 3'b000, EN_RW,    "jalr_wb");

    // jal
    instr(7'b1101111, 3'b000, 7'b0000000);
    step(0, 0,  3'b000, 3'b100, EN_FETCH, "jal_fetch");
    step(0, 1,  3'b000, 3'b100, EN_NONE,  "jal_decode");
    step(0, 10, 3'b000, 3'b100, EN_PC,    "jal_jump");
    step(0, 8,  3'b000, 3'b100, EN_RW,    "jal_wb");

    // lui
    instr(7'b0110111, 3'b000, 7'b0000000);
    step(0, 0,  3'b000, 3'b011, EN_FETCH, "lui_fetch");
    step(0, 1,  3'b000, 3'b011, EN_NONE,  "lui_decode");
    step(0, 13, 3'b000, 3'b011, EN_RW,    "lui_wb");

    // Illegal opcode: a stalled DECODE holds without flagging, then one pulse
    instr(7'b0000000, 3'b000, 7'b0000000);
    step(0, 0, 3'b000, 3'b000, EN_FETCH, "ill_fetch");
    stall = 1'b1;
    step(0, 1, 3'b000, 3'b000, EN_NONE,  "ill_stalled");
    stall = 1'b0;
    step(0, 1, 3'b000, 3'b000, EN_ILL,   "ill_decode");
    step(0, 0, 3'b000, 3'b000, EN_FETCH, "ill_after");

    // MEM_WAIT = 2 instance
    reset_dut(1);

    // lw: 3 FETCH, DECODE, MEMADR, 3 MEMREAD, MEMWB = 9 cycles
    instr(7'b0000011, 3'b010, 7'b0000000);
    step(1, 0, 3'b000, 3'b000, EN_NONE,  "lw_fetch0");
    step(1, 0, 3'b000, 3'b000, EN_NONE,  "lw_fetch1");
    step(1, 0, 3'b000, 3'b000, EN_FETCH, "lw_fetch2");
    step(1, 1, 3'b000, 3'b000, EN_NONE,  "lw_decode");
    step(1, 2, 3'b000, 3'b000, EN_NONE,  "lw_memadr");
    step(1, 3, 3'b000, 3'b000, EN_NONE,  "lw_memread0");
    step(1, 3, 3'b000, 3'b000, EN_NONE,  "lw_memread1");
    step(1, 3, 3'b000, 3'b000, EN_NONE,  "lw_memread2");
    step(1, 4, 3'b000, 3'b000, EN_RW,    "lw_memwb");

    // sw with a 3-cycle stall landing on the final MEMWRITE cycle
    instr(7'b0100011, 3'b010, 7'b0000000);
    step(1, 0, 3'b000, 3'b001, EN_NONE,  "sw_fetch0");
    step(1, 0, 3'b000, 3'b001, EN_NONE,  "sw_fetch1");
    step(1, 0, 3'b000, 3'b001, EN_FETCH, "sw_fetch2");
    step(1, 1, 3'b000, 3'b001, EN_NONE,  "sw_decode");
    step(1, 2, 3'b000, 3'b001, EN_NONE,  "sw_memadr");
    step(1, 5, 3'b000, 3'b001, EN_NONE,  "sw_memwrite0");
    step(1, 5, 3'b000, 3'b001, EN_NONE,  "sw_memwrite1");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 5, 3'b000, 3'b001, EN_NONE, "sw_stalled");
    stall = 1'b0;
    step(1, 5, 3'b000, 3'b001, EN_MW,    "sw_release");
    step(1, 0, 3'b000, 3'b001, EN_NONE,  "sw_next0");

    // Second sw, aborted by reset inside MEMWRITE
    step(1, 0, 3'b000, 3'b001, EN_NONE,  "swr_fetch1");
    step(1, 0, 3'b000, 3'b001, EN_FETCH, "swr_fetch2");
    step(1, 1, 3'b000, 3'b001, EN_NONE,  "swr_decode");
    step(1, 2, 3'b000, 3'b001, EN_NONE,  "swr_memadr");
    step(1, 5, 3'b000, 3'b001, EN_NONE,  "swr_memwrite0");
    rst = 1'b1;
    step(1, 5, 3'b000, 3'b001, EN_NONE,  "swr_rst_hold");
    rst = 1'b0;
    step(1, 0, 3'b000, 3'b001, EN_NONE,  "swr_after0");
    step(1, 0, 3'b000, 3'b001, EN_NONE,  "swr_after1");
    step(1, 0, 3'b000, 3'b001, EN_FETCH, "swr_after2");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending vectors, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
